// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_pkg
// Description : Shared types and constants for the pipeline hazard
//               controller: FSM state encoding, register-index width and
//               the default memory-wait timeout.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    // Width of a register-file index (x0..x31)
    localparam int REG_AW = 5;

    // Default bound on consecutive data-memory wait cycles
    localparam int DEFAULT_MEM_TIMEOUT = 200;

    // Controller FSM states; the encoding is exported on state_o for debug
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN     = 3'd1,
        MEMWAIT = 3'd2,
        ERROR   = 3'd3
    } state_e;

endpackage : hazard_pkg
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detect
// Description : Combinational load-use hazard compare between the load in
//               EX and the source registers of the instruction in ID.
//               x0 never creates a hazard. rs2 is always compared, which is
//               conservative for I-type instructions that do not use it.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect
    import hazard_pkg::*;
(
    input  logic              i_memRead,
    input  logic [REG_AW-1:0] i_rd,
    input  logic [REG_AW-1:0] i_rs1,
    input  logic [REG_AW-1:0] i_rs2,
    output logic              o_loadUse
);

    assign o_loadUse = i_memRead
                     && (i_rd != '0)
                     && ((i_rd == i_rs1) || (i_rd == i_rs2));

endmodule : hazard_detect
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline hazard and sequencing controller. Drives the PC
//               write enable, IF/ID stall/flush, ID/EX bubble and global
//               freeze from load-use hazards, taken branches, data-memory
//               wait requests and the core start signal. A watchdog moves
//               the FSM to a sticky ERROR state when a memory wait lasts
//               MEM_TIMEOUT cycles.
//               Optional macro HAZARD_CTRL_PERF_EN builds the stall, flush
//               and memory-wait performance counters; without it those
//               ports are tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = DEFAULT_MEM_TIMEOUT,
    parameter int TMO_W       = 8,
    parameter int CNT_W       = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic              idex_memread_i,
    input  logic [REG_AW-1:0] idex_rd_i,
    input  logic [REG_AW-1:0] ifid_rs1_i,
    input  logic [REG_AW-1:0] ifid_rs2_i,
    input  logic              branch_taken_i,
    input  logic              mem_stall_i,
    output logic              pc_write_o,
    output logic              ifid_stall_o,
    output logic              ifid_flush_o,
    output logic              idex_bubble_o,
    output logic              freeze_o,
    output logic              error_o,
    output logic [2:0]        state_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o,
    output logic [CNT_W-1:0]  memwait_cnt_o
);

    localparam logic [TMO_W-1:0] c_TIMEOUT = TMO_W'(MEM_TIMEOUT);

    state_e           r_state;
    state_e           w_nextState;
    logic [TMO_W-1:0] r_waitCnt;
    logic [TMO_W-1:0] w_nextWaitCnt;
    logic [TMO_W-1:0] w_waitInc;
    logic             r_error;
    logic             w_loadUse;
    logic             w_memWaitCycle;
    logic             w_useRunRules;
    logic             w_pcWrite;
    logic             w_ifidStall;
    logic             w_ifidFlush;
    logic             w_idexBubble;
    logic             w_freeze;

    hazard_detect u_detect (
        .i_memRead (idex_memread_i),
        .i_rd      (idex_rd_i),
        .i_rs1     (ifid_rs1_i),
        .i_rs2     (ifid_rs2_i),
        .o_loadUse (w_loadUse)
    );

    // The wait counter never exceeds the timeout value
    assign w_waitInc = (r_waitCnt >= c_TIMEOUT) ? c_TIMEOUT : (r_waitCnt + TMO_W'(1));

    // A MEMWAIT cycle that actually holds the pipeline (still running, memory still busy)
    assign w_memWaitCycle = (r_state == MEMWAIT) && start_i && mem_stall_i;

    // Next-state, wait-counter and control-output decode
    always_comb begin
        w_nextState   = r_state;
        w_nextWaitCnt = '0;
        w_pcWrite     = 1'b0;
        w_ifidStall   = 1'b0;
        w_ifidFlush   = 1'b0;
        w_idexBubble  = 1'b0;
        w_freeze      = 1'b0;
        w_useRunRules = 1'b0;

        case (r_state)
            IDLE: begin
                w_freeze    = 1'b1;
                w_ifidStall = 1'b1;
                if (start_i) begin
                    w_nextState = RUN;
                end
            end
            RUN: begin
                w_useRunRules = 1'b1;
            end
            MEMWAIT: begin
                if (w_memWaitCycle) begin
                    w_freeze    = 1'b1;
                    w_ifidStall = 1'b1;
                    if (w_waitInc == c_TIMEOUT) begin
                        w_nextState = ERROR;
                    end else begin
                        w_nextWaitCnt = w_waitInc;
                    end
                end else begin
                    // Memory released or core stopped: the cycle behaves like RUN
                    w_useRunRules = 1'b1;
                end
            end
            ERROR: begin
                w_freeze    = 1'b1;
                w_ifidStall = 1'b1;
            end
            default: begin
                w_freeze    = 1'b1;
                w_ifidStall = 1'b1;
                w_nextState = IDLE;
            end
        endcase

        if (w_useRunRules) begin
            if (!start_i) begin
                w_freeze    = 1'b1;
                w_ifidStall = 1'b1;
                w_nextState = IDLE;
            end else if (mem_stall_i) begin
                w_freeze      = 1'b1;
                w_ifidStall   = 1'b1;
                w_nextState   = MEMWAIT;
                w_nextWaitCnt = TMO_W'(1);
            end else if (w_loadUse) begin
                // A taken branch here is dropped: its operands are not ready yet
                w_ifidStall  = 1'b1;
                w_idexBubble = 1'b1;
                w_nextState  = RUN;
            end else if (branch_taken_i) begin
                w_pcWrite   = 1'b1;
                w_ifidFlush = 1'b1;
                w_nextState = RUN;
            end else begin
                w_pcWrite   = 1'b1;
                w_nextState = RUN;
            end
        end

        // While reset is asserted the pipeline sees IDLE controls regardless of state
        if (!rst_n_i) begin
            w_pcWrite    = 1'b0;
            w_ifidStall  = 1'b1;
            w_ifidFlush  = 1'b0;
            w_idexBubble = 1'b0;
            w_freeze     = 1'b1;
        end
    end

    // State register, memory-wait counter and sticky timeout flag
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state   <= IDLE;
            r_waitCnt <= '0;
            r_error   <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_waitCnt <= w_nextWaitCnt;
            if (w_nextState == ERROR) begin
                r_error <= 1'b1;
            end
        end
    end

    assign pc_write_o    = w_pcWrite;
    assign ifid_stall_o  = w_ifidStall;
    assign ifid_flush_o  = w_ifidFlush;
    assign idex_bubble_o = w_idexBubble;
    assign freeze_o      = w_freeze;
    assign error_o       = r_error;
    assign state_o       = r_state;

`ifdef HAZARD_CTRL_PERF_EN
    logic [CNT_W-1:0] r_stallCnt;
    logic [CNT_W-1:0] r_flushCnt;
    logic [CNT_W-1:0] r_memWaitCnt;

    // Free-running, wrapping event counters; a bubble marks a load-use stall cycle
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_stallCnt   <= '0;
            r_flushCnt   <= '0;
            r_memWaitCnt <= '0;
        end else begin
            if (w_idexBubble) begin
                r_stallCnt <= r_stallCnt + CNT_W'(1);
            end
            if (w_ifidFlush) begin
                r_flushCnt <= r_flushCnt + CNT_W'(1);
            end
            if (w_memWaitCycle) begin
                r_memWaitCnt <= r_memWaitCnt + CNT_W'(1);
            end
        end
    end

    assign stall_cnt_o   = r_stallCnt;
    assign flush_cnt_o   = r_flushCnt;
    assign memwait_cnt_o = r_memWaitCnt;
`else
    assign stall_cnt_o   = '0;
    assign flush_cnt_o   = '0;
    assign memwait_cnt_o = '0;
`endif

endmodule : hazard_ctrl
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl. A table of per-cycle
//               vectors covers reset, load-use, branch, memory-wait and
//               start/stop behaviour; hand-written sequences cover the
//               watchdog timeout and the performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int MEM_TIMEOUT = 4;
    localparam int TMO_W       = 8;
    localparam int CNT_W       = 32;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RUN  = 3'd1;
    localparam logic [2:0] S_MW   = 3'd2;
    localparam logic [2:0] S_ERR  = 3'd3;

    // {pc_write, ifid_stall, ifid_flush, idex_bubble, freeze}
    localparam logic [4:0] O_IDLE  = 5'b01001;
    localparam logic [4:0] O_FRZ   = 5'b01001;
    localparam logic [4:0] O_RUN   = 5'b10000;
    localparam logic [4:0] O_STALL = 5'b01010;
    localparam logic [4:0] O_FLUSH = 5'b10100;

`ifdef HAZARD_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct packed {
        logic       rst;
        logic       start;
        logic       memRd;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       br;
        logic       ms;
        logic [4:0] outs;
        logic       err;
        logic [2:0] st;
    } vec_t;

    logic             clk_i = 1'b0;
    logic             rst_n_i;
    logic             start_i;
    logic             idex_memread_i;
    logic [4:0]       idex_rd_i;
    logic [4:0]       ifid_rs1_i;
    logic [4:0]       ifid_rs2_i;
    logic             branch_taken_i;
    logic             mem_stall_i;
    logic             pc_write_o;
    logic             ifid_stall_o;
    logic             ifid_flush_o;
    logic             idex_bubble_o;
    logic             freeze_o;
    logic             error_o;
    logic [2:0]       state_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;
    logic [CNT_W-1:0] memwait_cnt_o;

    int nChecks = 0;
    int nErrors = 0;

    vec_t vecs [26];

    hazard_ctrl #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TMO_W       (TMO_W),
        .CNT_W       (CNT_W)
    ) dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .start_i        (start_i),
        .idex_memread_i (idex_memread_i),
        .idex_rd_i      (idex_rd_i),
        .ifid_rs1_i     (ifid_rs1_i),
        .ifid_rs2_i     (ifid_rs2_i),
        .branch_taken_i (branch_taken_i),
        .mem_stall_i    (mem_stall_i),
        .pc_write_o     (pc_write_o),
        .ifid_stall_o   (ifid_stall_o),
        .ifid_flush_o   (ifid_flush_o),
        .idex_bubble_o  (idex_bubble_o),
        .freeze_o       (freeze_o),
        .error_o        (error_o),
        .state_o        (state_o),
        .stall_cnt_o    (stall_cnt_o),
        .flush_cnt_o    (flush_cnt_o),
        .memwait_cnt_o  (memwait_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic vec_t mk(input logic rst, input logic start, input logic memRd,
                                input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic br, input logic ms,
                                input logic [4:0] outs, input logic err, input logic [2:0] st);
        vec_t v;
        v.rst = rst; v.start = start; v.memRd = memRd;
        v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
        v.br = br; v.ms = ms;
        v.outs = outs; v.err = err; v.st = st;
        return v;
    endfunction

    // Drive one cycle of inputs, check the combinational outputs mid-cycle, then clock
    task automatic runVec(input vec_t v, input int id);
        logic [8:0] act;
        logic [8:0] exp;
        rst_n_i        = v.rst;
        start_i        = v.start;
        idex_memread_i = v.memRd;
        idex_rd_i      = v.rd;
        ifid_rs1_i     = v.rs1;
        ifid_rs2_i     = v.rs2;
        branch_taken_i = v.br;
        mem_stall_i    = v.ms;
        #3;
        act = {pc_write_o, ifid_stall_o, ifid_flush_o, idex_bubble_o, freeze_o, error_o, state_o};
        exp = {v.outs, v.err, v.st};
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL vec%0d: got pcw/stall/flush/bubble/freeze=%b err=%b state=%0d, expected %b err=%b state=%0d",
                     id, act[8:4], act[3], act[2:0], exp[8:4], exp[3], exp[2:0]);
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkCnt(input string name, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    initial begin
        //                 rst st mr rd rs1 rs2 br ms  outs     err state
        vecs[0]  = mk(0, 1, 0, 0, 0, 0, 0, 0, O_IDLE,  0, S_IDLE);  // reset cycle
        vecs[1]  = mk(1, 1, 0, 0, 0, 0, 0, 0, O_IDLE,  0, S_IDLE);  // IDLE -> RUN
        vecs[2]  = mk(1, 1, 0, 0, 0, 0, 0, 0, O_RUN,   0, S_RUN);
        vecs[3]  = mk(1, 1, 1, 5, 5, 0, 0, 0, O_STALL, 0, S_RUN);   // load-use on rs1
        vecs[4]  = mk(1, 1, 0, 0, 5, 0, 0, 0, O_RUN,   0, S_RUN);   // bubble in EX
        vecs[5]  = mk(1, 1, 1, 0, 0, 0, 0, 0, O_RUN,   0, S_RUN);   // x0 never stalls
        vecs[6]  = mk(1, 1, 1, 7, 3, 7, 0, 0, O_STALL, 0, S_RUN);   // load-use on rs2
        vecs[7]  = mk(1, 1, 1, 9, 9, 0, 1, 0, O_STALL, 0, S_RUN);   // stall beats branch
        vecs[8]  = mk(1, 1, 0, 0, 0, 0, 1, 0, O_FLUSH, 0, S_RUN);   // branch resolves
        vecs[9]  = mk(1, 1, 1, 4, 5, 6, 0, 0, O_RUN,   0, S_RUN);   // load, no match
        vecs[10] = mk(1, 1, 0, 0, 0, 0, 0, 1, O_FRZ,   0, S_RUN);   // wait cycle 1
        vecs[11] = mk(1, 1, 0, 0, 0, 0, 0, 1, O_FRZ,   0, S_MW);    // wait cycle 2
        vecs[12] = mk(1, 1, 0, 0, 0, 0, 0, 1, O_FRZ,   0, S_MW);    // wait cycle 3
        vecs[13] = mk(1, 1, 0, 0, 0, 0, 1, 0, O_FLUSH, 0, S_MW);    // RUN rules on exit
        vecs[14] = mk(1, 1, 0, 0, 0, 0, 0, 0, O_RUN,   0, S_RUN);
        vecs[15] = mk(1, 0, 0, 0, 0, 0, 0, 0, O_IDLE,  0, S_RUN);   // stop in RUN
        vecs[16] = mk(1, 0, 0, 0, 0, 0, 0, 0, O_IDLE,  0, S_IDLE);
        vecs[17] = mk(1, 1, 0, 0, 0, 0, 0, 0, O_IDLE,  0, S_IDLE);
        vecs[18] = mk(1, 1, 0, 0, 0, 0, 0, 1, O_FRZ,   0, S_RUN);
        vecs[19] = mk(1, 0, 0, 0, 0, 0, 0, 1, O_IDLE,  0, S_MW);    // stop in MEMWAIT
        vecs[20] = mk(1, 1, 0, 0, 0, 0, 0, 0, O_IDLE,  0, S_IDLE);
        vecs[21] = mk(1, 1, 0, 0, 0, 0, 0, 0, O_RUN,   0, S_RUN);
        vecs[22] = mk(1, 1, 1, 5, 5, 0, 0, 1, O_FRZ,   0, S_RUN);   // mem stall beats load-use
        vecs[23] = mk(1, 1, 1, 5, 5, 0, 0, 0, O_STALL, 0, S_MW);    // load-use on MEMWAIT exit
        vecs[24] = mk(0, 1, 0, 0, 0, 0, 0, 0, O_IDLE,  0, S_RUN);   // reset from RUN
        vecs[25] = mk(1, 0, 0, 0, 0, 0, 0, 0, O_IDLE,  0, S_IDLE);

        rst_n_i        = 1'b0;
        start_i        = 1'b0;
        idex_memread_i = 1'b0;
        idex_rd_i      = '0;
        ifid_rs1_i     = '0;
        ifid_rs2_i     = '0;
        branch_taken_i = 1'b0;
        mem_stall_i    = 1'b0;
        @(posedge clk_i);
        #1;

        for (int i = 0; i < 26; i++) begin
            runVec(vecs[i], i);
        end

        // Watchdog: stall held until the 4th wait cycle ends, then sticky ERROR until reset
        runVec(mk(1, 1, 0, 0, 0, 0, 0, 0, O_IDLE, 0, S_IDLE), 100);
        runVec(mk(1, 1, 0, 0, 0, 0, 0, 1, O_FRZ,  0, S_RUN),  101);
        runVec(mk(1, 1, 0, 0, 0, 0, 0, 1, O_FRZ,  0, S_MW),   102);
        runVec(mk(1, 1, 0, 0, 0, 0, 0, 1, O_FRZ,  0, S_MW),   103);
        runVec(mk(1, 1, 0, 0, 0, 0, 0, 1, O_FRZ,  0, S_MW),   104);
        runVec(mk(1, 1, 0, 0, 0, 0, 0, 1, O_IDLE, 1, S_ERR),  105);
        runVec(mk(1, 1, 0, 0, 0, 0, 0, 0, O_IDLE, 1, S_ERR),  106);
        runVec(mk(1, 0, 0, 0, 0, 0, 1, 0, O_IDLE, 1, S_ERR),  107);
        runVec(mk(0, 1, 0, 0, 0, 0, 0, 0, O_IDLE, 1, S_ERR),  108);
        runVec(mk(1, 0, 0, 0, 0, 0, 0, 0, O_IDLE, 0, S_IDLE), 109);

        // Counters cleared by the reset above
        checkCnt("stall_cnt_reset",   stall_cnt_o,   '0);
        checkCnt("flush_cnt_reset",   flush_cnt_o,   '0);
        checkCnt("memwait_cnt_reset", memwait_cnt_o, '0);

        // One load-use stall, two flushes, a 3-cycle memory wait
        runVec(mk(1, 1, 0, 0, 0, 0, 0, 0, O_IDLE,  0, S_IDLE), 200);
        runVec(mk(1, 1, 1, 3, 3, 0, 0, 0, O_STALL, 0, S_RUN),  201);
        runVec(mk(1, 1, 0, 0, 0, 0, 1, 0, O_FLUSH, 0, S_RUN),  202);
        runVec(mk(1, 1, 0, 0, 0, 0, 1, 0, O_FLUSH, 0, S_RUN),  203);
        runVec(mk(1, 1, 0, 0, 0, 0, 0, 1, O_FRZ,   0, S_RUN),  204);
        runVec(mk(1, 1, 0, 0, 0, 0, 0, 1, O_FRZ,   0, S_MW),   205);
        runVec(mk(1, 1, 0, 0, 0, 0, 0, 1, O_FRZ,   0, S_MW),   206);
        runVec(mk(1, 1, 0, 0, 0, 0, 0, 0, O_RUN,   0, S_MW),   207);

        checkCnt("stall_cnt",   stall_cnt_o,   PERF ? CNT_W'(1) : '0);
        checkCnt("flush_cnt",   flush_cnt_o,   PERF ? CNT_W'(2) : '0);
        checkCnt("memwait_cnt", memwait_cnt_o, PERF ? CNT_W'(2) : '0);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule : tb_hazard_ctrl
`default_nettype wire

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage RISC-V core. It generates the IF/ID stall and flush strobes, the PC write enable, the ID/EX bubble insert and a global freeze from four inputs: load-use hazards, taken branches resolved in ID, data-memory wait requests and the core start signal. A small FSM tracks run, idle, memory-wait and error conditions, and a watchdog bounds memory waits. It sits beside the IF/ID register, PC register and ID/EX register and drives all of their control inputs.

## Interface
Parameters:
- MEM_TIMEOUT, 200: maximum number of consecutive memory-wait cycles before the error state; range 1 to 2^TMO_W-1
- TMO_W, 8: width of the memory-wait cycle counter
- CNT_W, 32: width of the performance counters

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_n_i  in  1  reset, synchronous, active-low
- start_i  in  1  core run enable; low means freeze
- idex_memread_i  in  1  the instruction in EX is a load
- idex_rd_i  in  5  destination register of the instruction in EX
- ifid_rs1_i, ifid_rs2_i  in  5 each  source registers of the instruction in ID
- branch_taken_i  in  1  branch in ID resolved as taken
- mem_stall_i  in  1  data memory busy; the whole pipeline must hold
- pc_write_o  out  1  PC register load enable
- ifid_stall_o  out  1  IF/ID hold
- ifid_flush_o  out  1  IF/ID clear to zero (NOP)
- idex_bubble_o  out  1  force ID/EX control fields to zero
- freeze_o  out  1  hold every pipeline register (EX/MEM and MEM/WB included)
- error_o  out  1  sticky memory-wait timeout flag
- state_o  out  3  current FSM state encoding, for debug
- stall_cnt_o, flush_cnt_o, memwait_cnt_o  out  CNT_W each  performance counters (see Configuration)

## Operation
- FSM states: IDLE, RUN, MEMWAIT, ERROR.
- Load-use hazard (combinational): idex_memread_i & (idex_rd_i != 0) & (idex_rd_i == ifid_rs1_i | idex_rd_i == ifid_rs2_i). The rs2 compare is intentionally conservative for I-type instructions.
- IDLE: freeze_o=1, pc_write_o=0, ifid_stall_o=1. Transition to RUN when start_i=1.
- RUN: outputs are resolved per cycle by priority:
  1. start_i=0: IDLE outputs are driven this cycle; next state is IDLE.
  2. mem_stall_i=1: freeze_o=1, pc_write_o=0, ifid_stall_o=1; next state is MEMWAIT; wait counter loads 1.
  3. Load-use hazard: pc_write_o=0, ifid_stall_o=1, idex_bubble_o=1. A taken branch in the same cycle is ignored because its operands are not ready; the branch resolves again after the stall.
  4. branch_taken_i=1: pc_write_o=1, ifid_flush_o=1.
  5. Otherwise: pc_write_o=1 and all other outputs 0.
- MEMWAIT: freeze outputs are driven as in RUN case 2 and the counter increments each cycle.
  - mem_stall_i=0: return to RUN. Outputs that cycle are evaluated with the RUN rules.
  - Counter reaches MEM_TIMEOUT while mem_stall_i=1: go to ERROR.
  - start_i=0: go to IDLE.
- ERROR: IDLE outputs are driven and error_o=1. The state is left only by reset.
- ifid_stall_o and ifid_flush_o are never both 1. Stall has priority.

## Timing
- Control outputs are combinational from the registered state and the current inputs, with zero latency. State, counter and error_o update on the rising edge.
- Reset values (rst_n_i=0 sampled on the edge): state=IDLE, wait counter=0, error_o=0, all performance counters=0. During the reset cycle and afterward, outputs follow the IDLE rules: freeze_o=1, ifid_stall_o=1, pc_write_o=0, ifid_flush_o=0, idex_bubble_o=0.
- Reset asserted mid-MEMWAIT or in ERROR returns to IDLE on the next edge.
- A load-use stall lasts exactly one cycle. The next cycle the bubble is in EX and idex_memread_i drops.
- The wait counter saturates at MEM_TIMEOUT and clears on any exit from MEMWAIT.

## Configuration
- HAZARD_CTRL_PERF_EN defined: the three counters increment by 1 per qualifying cycle and wrap modulo 2^CNT_W.
  - stall_cnt_o counts load-use stall cycles.
  - flush_cnt_o counts cycles with ifid_flush_o=1.
  - memwait_cnt_o counts cycles spent in MEMWAIT.
- HAZARD_CTRL_PERF_EN undefined: the counter registers are not built and the three ports are tied to 0.

## Structure
- hazard_pkg holds:
  - the state enum: IDLE=0, RUN=1, MEMWAIT=2, ERROR=3
  - the register-index width constant REG_AW=5
  - the default MEM_TIMEOUT value
- One sub-module, hazard_detect: the purely combinational load-use compare. hazard_ctrl instantiates it once.

## Test plan
- Reset, then start_i=1 → the state is IDLE for the reset cycle, then RUN. While IDLE, freeze_o=1 and pc_write_o=0.
- RUN with idex_memread_i=1, idex_rd_i=5, ifid_rs1_i=5 → exactly one cycle of pc_write_o=0, ifid_stall_o=1, idex_bubble_o=1. Repeat with idex_rd_i=0 → no stall.
- Load-use hazard plus branch_taken_i=1 in the same cycle → stall only, ifid_flush_o=0. Next cycle branch_taken_i=1 alone → ifid_flush_o=1, pc_write_o=1.
- mem_stall_i high for 3 cycles → freeze_o=1 for 3 cycles, with state MEMWAIT for cycles 2–3. RUN resumes when mem_stall_i=0. With HAZARD_CTRL_PERF_EN defined, memwait_cnt_o=2.
- MEM_TIMEOUT=4 with mem_stall_i held high → ERROR after the 4th wait cycle and error_o=1. The state holds until rst_n_i=0, then returns to IDLE with error_o=0.
- start_i dropped during RUN and during MEMWAIT → IDLE outputs are driven in that same cycle. start_i reasserted → RUN next cycle.
